// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/result bundle for seq_shifter.
//   start  - request, sampled only while the shifter is idle
//   op     - 00 LSL, 01 LSR, 10 ASR, 11 ROR (sampled with start)
//   shamt  - shift amount 0..WIDTH-1 (sampled with start)
//   d_in   - operand (sampled with start)
//   busy   - high whenever the shifter is not idle
//   done   - one-cycle pulse when d_out has just been updated
//   d_out  - result register, held until the next operation completes
// master modport drives the request; slave modport is the shifter side.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] d_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d_out;

    modport master (
        output start, op, shamt, d_in,
        input  busy, done, d_out
    );

    modport slave (
        input  start, op, shamt, d_in,
        output busy, done, d_out
    );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one bit position per clock.
// Modes LSL/LSR/ASR/ROR, shift range 0..WIDTH-1, start/busy/done handshake.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - seq_shifter_if slave modport (start/op/shamt/d_in in, busy/done/d_out out)
// WIDTH must be a power of two and at least 2; the interface instance must use the same WIDTH.
module seq_shifter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_shifter_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       mode_q, mode_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] shifted;

    // One-position step of the working register in the captured mode.
    always_comb begin
        shifted = work_q;
        unique case (mode_q)
            2'b00:   shifted = {work_q[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work_q[WIDTH-1:1]};
            2'b10:   shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shifted = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    work_d = bus.d_in;
                    mode_d = bus.op;
                    cnt_d  = bus.shamt;
                    // Zero shift skips SHIFT entirely: result is the operand itself.
                    if (bus.shamt == '0) begin
                        dout_d  = bus.d_in;
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHW'(1);
                // Last step: publish the shifted value on the same edge.
                if (cnt_q == SHW'(1)) begin
                    dout_d  = shifted;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);
    assign bus.d_out = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed checks on an 8-bit seq_shifter plus a randomised
// run on a 32-bit instance against a combinational reference.
// Inputs are driven and outputs sampled on the falling edge.
module tb_seq_shifter;
    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] dout8_model = 8'h00;

    seq_shifter_if #(.WIDTH(8))  bus8 ();
    seq_shifter_if #(.WIDTH(32)) bus32 ();

    seq_shifter #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    seq_shifter #(.WIDTH(32)) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model32(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = 32'($signed(d) >>> s);
            default: r = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
        endcase
        return r;
    endfunction

    // One 8-bit operation. Cycle 0 is the falling-edge slot where start is driven.
    // In cycle k (k >= 1) outputs are checked, then start is re-pulsed if k is
    // pulse_a/pulse_b, with scrambled operands that must not matter.
    task automatic op8(input string tag, input logic [1:0] op, input logic [7:0] din,
                       input logic [2:0] sh, input logic [7:0] exp,
                       input int pulse_a, input int pulse_b, input bit rel);
        int lat;
        lat = int'(sh) + 1;
        @(negedge clk);
        if (rel) reset_n = 1'b1;
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.d_in  = din;
        bus8.shamt = sh;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check({tag, " busy"}, 32'(bus8.busy), 32'(k <= lat));
            check({tag, " done"}, 32'(bus8.done), 32'(k == lat));
            if (k < lat) check({tag, " d_out hold"}, 32'(bus8.d_out), 32'(dout8_model));
            else         check({tag, " d_out"}, 32'(bus8.d_out), 32'(exp));
            bus8.start = (k == pulse_a) || (k == pulse_b);
            bus8.d_in  = 8'h00;
            bus8.op    = op ^ 2'b01;
            bus8.shamt = sh ^ 3'b101;
        end
        bus8.start  = 1'b0;
        dout8_model = exp;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus8.start  = 1'b0;
        bus8.op     = 2'b00;
        bus8.shamt  = '0;
        bus8.d_in   = '0;
        bus32.start = 1'b0;
        bus32.op    = 2'b00;
        bus32.shamt = '0;
        bus32.d_in  = '0;

        repeat (3) @(negedge clk);
        check("reset busy8", 32'(bus8.busy), 32'd0);
        check("reset done8", 32'(bus8.done), 32'd0);
        check("reset dout8", 32'(bus8.d_out), 32'd0);
        check("reset busy32", 32'(bus32.busy), 32'd0);
        check("reset dout32", bus32.d_out, 32'd0);

        // First request coincides with reset release.
        op8("lsr_b6_2", 2'b01, 8'hB6, 3'd2, 8'h2D, -1, -1, 1'b1);
        op8("asr_96_3", 2'b10, 8'h96, 3'd3, 8'hF2, -1, -1, 1'b0);
        op8("lsl_81_7", 2'b00, 8'h81, 3'd7, 8'h80, -1, -1, 1'b0);
        op8("ror_81_1", 2'b11, 8'h81, 3'd1, 8'hC0, -1, -1, 1'b0);
        op8("zero_5a",  2'b10, 8'h5A, 3'd0, 8'h5A, -1, -1, 1'b0);
        op8("ror_96_5", 2'b11, 8'h96, 3'd5, 8'hB4, -1, -1, 1'b0);
        op8("asr_7f_6", 2'b10, 8'h7F, 3'd6, 8'h01, -1, -1, 1'b0);
        op8("lsr_ff_5", 2'b01, 8'hFF, 3'd5, 8'h07,  2,  6, 1'b0);

        // Asynchronous reset in the middle of cycle 3 of a ROR.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = 2'b11;
        bus8.d_in  = 8'h0F;
        bus8.shamt = 3'd6;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus8.start = 1'b0;
            check("ror_rst busy", 32'(bus8.busy), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("rst busy", 32'(bus8.busy), 32'd0);
        check("rst done", 32'(bus8.done), 32'd0);
        check("rst dout", 32'(bus8.d_out), 32'd0);
        dout8_model = 8'h00;
        op8("lsl_01_4", 2'b00, 8'h01, 3'd4, 8'h10, -1, -1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("idle done", 32'(bus8.done), 32'd0);
        end

        // Randomised 32-bit run, back-to-back.
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  rop;
            logic [31:0] rd;
            logic [4:0]  rs;
            int          seen;
            rop  = 2'($urandom_range(0, 3));
            rd   = $urandom;
            rs   = 5'($urandom_range(0, 31));
            seen = -1;
            @(negedge clk);
            bus32.start = 1'b1;
            bus32.op    = rop;
            bus32.d_in  = rd;
            bus32.shamt = rs;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                bus32.start = 1'b0;
                bus32.d_in  = ~rd;
                if (bus32.done) begin
                    seen = k;
                    break;
                end
            end
            check("w32 latency", 32'(seen), 32'(int'(rs) + 1));
            check("w32 d_out", bus32.d_out, model32(rop, rd, rs));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, multi-cycle shifter. It is the sequential successor of the 8-bit combinational logical-right shifter:

- Width is generalised by `WIDTH`.
- The full shift range `0..WIDTH-1` is supported.
- Four shift modes are provided: LSL, LSR, ASR and ROR.
- Operation is one bit position per clock, under a start/busy/done handshake.

It sits in the counter_shifter datapath as the shared shift resource for wide operands.

## Interface

Parameters:

- `WIDTH`, default 8. Operand width. Must be a power of two and at least 2.
- `SHW`, local, fixed to `$clog2(WIDTH)`. Width of the shift-amount field. Not overridable.

Ports:

- `clk`, input, 1. Single clock, rising edge.
- `reset_n`, input, 1. Asynchronous, active-low reset.
- `start`, input, 1. Request. Sampled only in IDLE.
- `op`, input, 2. Mode: 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROR. Sampled with `start`.
- `shamt`, input, SHW. Shift amount, 0..WIDTH-1. Sampled with `start`.
- `d_in`, input, WIDTH. Operand. Sampled with `start`.
- `busy`, output, 1. High whenever state is not IDLE.
- `done`, output, 1. One-cycle pulse in the DONE state.
- `d_out`, output, WIDTH. Result register. Holds its value until the next operation completes.

## Operation

- States: IDLE, SHIFT, DONE.
- Internal registers:
  - `work` (WIDTH bits)
  - `mode` (2 bits)
  - `cnt` (SHW bits)

**IDLE:**
- If `start` = 1:
  - `work` <= `d_in`, `mode` <= `op`, `cnt` <= `shamt`.
  - If `shamt` = 0, go to DONE and load `d_out` <= `d_in`.
  - Otherwise go to SHIFT.
- If `start` = 0, stay in IDLE.

**SHIFT (each cycle):** `work` shifts one position according to `mode`, and `cnt` decrements.
- LSL: `{work[W-2:0], 0}`
- LSR: `{0, work[W-1:1]}`
- ASR: `{work[W-1], work[W-1:1]}`
- ROR: `{work[0], work[W-1:1]}`

**Leaving SHIFT:** when `cnt` = 1 at the edge, the same edge does the following:
- Performs the final shift.
- Loads `d_out` with the shifted value.
- Moves the state to DONE.

**DONE:** `done` = 1 for exactly one cycle, then unconditional return to IDLE.

**Other rules:**
- `start` while `busy` = 1 is ignored, including in the DONE cycle. No queuing.
- Changes on `op`, `shamt` or `d_in` after the sampling edge have no effect on the operation in flight.
- `d_out` changes only on the edge that enters DONE. It is stable in all other cycles.
- Result is identical to the combinational equivalent:
  - LSL: `d_in << shamt`
  - LSR: `d_in >> shamt`
  - ASR: `$signed(d_in) >>> shamt`
  - ROR: rotate right by `shamt`
- Reset (`reset_n` = 0, asynchronous, at any time including mid-SHIFT):
  - State goes to IDLE.
  - `work`, `mode`, `cnt` and `d_out` go to 0.
  - `busy` = 0 and `done` = 0.
  - The in-flight operation is discarded.
- First `start` is honoured at the first rising edge after `reset_n` deasserts.

## Timing

- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- `busy` is high in cycles 1 through `shamt`+1.
- `done` is high in cycle `shamt`+1 only.
- `d_out` is valid from cycle `shamt`+1 onward.
- Latency is `shamt`+1 cycles. The minimum is 1 (for `shamt` = 0); the maximum is WIDTH (for `shamt` = WIDTH-1).
- Back-to-back: the next `start` is accepted at the earliest in cycle `shamt`+2, i.e. the first IDLE cycle. Throughput is one operation per `shamt`+2 cycles.
- Reset values of all outputs:
  - `busy` = 0
  - `done` = 0
  - `d_out` = 0

## Test plan

1. LSR, WIDTH = 8, `d_in` = 8'hB6, `shamt` = 2.
   - Expect `busy` in cycles 1–3, `done` in cycle 3, `d_out` = 8'h2D.
2. ASR, `d_in` = 8'h96, `shamt` = 3.
   - Expect `d_out` = 8'hF2 and `done` in cycle 4.
   - Then LSL, `d_in` = 8'h81, `shamt` = 7: expect `d_out` = 8'h80 and `done` in cycle 8.
3. ROR, `d_in` = 8'h81, `shamt` = 1.
   - Expect `d_out` = 8'hC0.
   - Then `shamt` = 0 with `d_in` = 8'h5A, any `op`: expect `done` in cycle 1 and `d_out` = 8'h5A.
4. LSR, `d_in` = 8'hFF, `shamt` = 5. Pulse `start` again in cycles 2 and 6 (the DONE cycle) with `d_in` = 8'h00.
   - Both extra pulses are ignored.
   - Expect `d_out` = 8'h07 and a single `done` pulse.
5. Start ROR, `d_in` = 8'h0F, `shamt` = 6. Drop `reset_n` asynchronously mid-cycle 3.
   - Expect `busy` = 0, `done` = 0 and `d_out` = 0 immediately.
   - No `done` after release.
   - A new LSL, `d_in` = 8'h01, `shamt` = 4, is accepted on the first edge after release and yields 8'h10.
6. WIDTH = 32, random `op`/`d_in`/`shamt`, 1000 operations.
   - Each `d_out` matches the combinational model.
   - Each latency equals `shamt`+1.
